// File: rtl/jt12_timer_bank.sv
// jt12_timer_bank
//   Bank of NTIMERS up-counting FM timers (YM2612/YM3438 timer A/B style)
//   sharing a single clock enable. Every channel has its own prescaler,
//   reload value, run/stop control, periodic/one-shot mode, sticky flag and
//   IRQ mask. The bank drives the CPU interrupt line and the CSM key-on
//   request.
//
// Optional feature macro: JT12_TIMER_CSM_EN
//   defined   : csm_keyon pulses together with overflow[0] while csm_mode=1
//   undefined : csm_keyon is tied low and csm_mode is ignored
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   clk_en       clock enable; counting only advances when high
//   start_value  channel i reload value at [i*CW +: CW]
//   prescale     channel i prescaler at [i*PW +: PW]; counter steps every
//                prescale+1 enabled cycles
//   load         1 = channel running, 0 = stopped and preloaded
//   oneshot      1 = freeze after first overflow until load is cycled
//   clr_flag     sticky flag clear (level, wins over a same-cycle set)
//   enable_irq   per-channel IRQ mask
//   csm_mode     CSM enable for channel 0
//   flag         sticky overflow flags
//   overflow     one-clk overflow pulses (registered)
//   irq_n        registered ~|(flag & enable_irq)
//   csm_keyon    one-clk CSM key-on pulse
//
// Handshake: there is no valid/ready traffic here; load is a plain level,
// clr_flag a plain level, and all outputs are registered single-clock
// pulses or levels.

module jt12_timer_bank #(
    parameter int NTIMERS = 2,
    parameter int CW      = 10,
    parameter int PW      = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic [NTIMERS*CW-1:0]   start_value,
    input  logic [NTIMERS*PW-1:0]   prescale,
    input  logic [NTIMERS-1:0]      load,
    input  logic [NTIMERS-1:0]      oneshot,
    input  logic [NTIMERS-1:0]      clr_flag,
    input  logic [NTIMERS-1:0]      enable_irq,
    input  logic                    csm_mode,
    output logic [NTIMERS-1:0]      flag,
    output logic [NTIMERS-1:0]      overflow,
    output logic                    irq_n,
    output logic                    csm_keyon
);

    logic [CW-1:0]      cnt   [NTIMERS];
    logic [PW-1:0]      presc [NTIMERS];
    logic [NTIMERS-1:0] done;
    // Previous load level: the first cycle load is seen high still preloads,
    // so counting begins on the following enabled cycle.
    logic [NTIMERS-1:0] load_q;
    logic [NTIMERS-1:0] step;
    logic [NTIMERS-1:0] ovf_evt;

    // A step happens when the prescaler has reached its terminal value.
    // ">=" keeps the channel sane if prescale is lowered below the running
    // prescaler value (it steps immediately instead of wrapping through 2^PW).
    always_comb begin
        step    = '0;
        ovf_evt = '0;
        for (int i = 0; i < NTIMERS; i++) begin
            step[i]    = clk_en & load[i] & load_q[i] & ~done[i] &
                         (presc[i] >= prescale[i*PW +: PW]);
            ovf_evt[i] = step[i] & (&cnt[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTIMERS; i++) begin
                cnt[i]   <= '0;
                presc[i] <= '0;
            end
            done     <= '0;
            load_q   <= '0;
            flag     <= '0;
            overflow <= '0;
            irq_n    <= 1'b1;
        end else begin
            load_q   <= load;
            overflow <= ovf_evt;
            // Uses the flag value before this edge: irq_n trails flag by one clk.
            irq_n    <= ~|(flag & enable_irq);
            for (int i = 0; i < NTIMERS; i++) begin
                if (!load[i] || !load_q[i]) begin
                    cnt[i]   <= start_value[i*CW +: CW];
                    presc[i] <= '0;
                    done[i]  <= 1'b0;
                end else if (clk_en && !done[i]) begin
                    if (step[i]) begin
                        presc[i] <= '0;
                        if (ovf_evt[i]) begin
                            cnt[i] <= start_value[i*CW +: CW];
                            if (oneshot[i])
                                done[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end else begin
                        presc[i] <= presc[i] + 1'b1;
                    end
                end
                // Flag follows the registered pulse; a clear in the same cycle wins.
                if (clr_flag[i])
                    flag[i] <= 1'b0;
                else if (overflow[i])
                    flag[i] <= 1'b1;
            end
        end
    end

`ifdef JT12_TIMER_CSM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            csm_keyon <= 1'b0;
        else
            csm_keyon <= ovf_evt[0] & csm_mode;
    end
`else
    logic unused_csm_mode;
    assign unused_csm_mode = csm_mode;
    assign csm_keyon       = 1'b0;
`endif

endmodule

// File: tb/tb_jt12_timer_bank.sv
// Directed bench for jt12_timer_bank (NTIMERS=2, CW=10, PW=9).
module tb_jt12_timer_bank;
  localparam int NT = 2;
  localparam int CW = 10;
  localparam int PW = 9;
  localparam int W  = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              clk_en;
  logic [NT*CW-1:0]  start_value;
  logic [NT*PW-1:0]  prescale;
  logic [NT-1:0]     load, oneshot, clr_flag, enable_irq;
  logic              csm_mode;
  logic [NT-1:0]     flag, overflow;
  logic              irq_n, csm_keyon;

  jt12_timer_bank #(.NTIMERS(NT), .CW(CW), .PW(PW)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .start_value(start_value), .prescale(prescale),
    .load(load), .oneshot(oneshot), .clr_flag(clr_flag),
    .enable_irq(enable_irq), .csm_mode(csm_mode),
    .flag(flag), .overflow(overflow), .irq_n(irq_n), .csm_keyon(csm_keyon)
  );

`ifdef JT12_TIMER_CSM_EN
  localparam logic CSM_EXP = 1'b1;
`else
  localparam logic CSM_EXP = 1'b0;
`endif

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until overflow[ch] is seen high (bounded by budget).
  task automatic wait_ovf(input int ch, input int budget, input bit half, output int n);
    n = 0;
    do begin
      if (half) clk_en = ~clk_en;
      tick();
      n++;
    end while (!overflow[ch] && n < budget);
  endtask

  task automatic set_ch(input int ch, input int sv, input int ps);
    start_value[ch*CW +: CW] = sv[CW-1:0];
    prescale[ch*PW +: PW]    = ps[PW-1:0];
  endtask

  int n;
  int hits;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clk_en = 1'b1; start_value = '0; prescale = '0;
    load = '0; oneshot = '0; clr_flag = '0; enable_irq = '0; csm_mode = 1'b0;
    #12;
    check("rst_flag", flag, 0);
    check("rst_overflow", overflow, 0);
    check("rst_irq_n", irq_n, 1);
    check("rst_csm", csm_keyon, 0);
    #10 rst = 1'b0;
    tick();

    // ---- 1: periodic ch0, start 1023, prescale 23 ----
    set_ch(0, 1023, 23);
    load[0] = 1'b1;
    exp_q.push_back(25);   // preload edge + 24 ticks
    exp_q.push_back(24);
    exp_q.push_back(24);
    for (int k = 0; k < 3; k++) begin
      wait_ovf(0, 100, 1'b0, n);
      check("ch0_period", n, exp_q.pop_front());
    end
    tick();
    check("ch0_pulse_width", overflow[0], 0);
    check("ch0_flag_set", flag[0], 1);
    // half-rate clk_en: 24 enabled ticks span 48 edges
    wait_ovf(0, 100, 1'b0, n);
    check("ch0_period_pre_half", n, 23);
    wait_ovf(0, 200, 1'b1, n);
    check("ch0_period_half_en", n, 48);
    clk_en = 1'b1;
    load[0] = 1'b0; clr_flag[0] = 1'b1;
    tick();
    clr_flag[0] = 1'b0;
    tick();
    check("ch0_flag_cleared", flag[0], 0);

    // ---- 2: one-shot ch1, start 1020, prescale 383 ----
    set_ch(1, 1020, 383);
    oneshot[1] = 1'b1; load[1] = 1'b1;
    wait_ovf(1, 2000, 1'b0, n);
    check("ch1_oneshot_first", n, 1537);
    hits = 0;
    for (int k = 0; k < 2000; k++) begin
      tick();
      if (overflow[1]) hits++;
    end
    check("ch1_oneshot_none_more", hits, 0);
    check("ch1_flag", flag[1], 1);
    load[1] = 1'b0;
    tick();
    load[1] = 1'b1;
    wait_ovf(1, 2000, 1'b0, n);
    check("ch1_oneshot_reload", n, 1537);
    load[1] = 1'b0; oneshot[1] = 1'b0; clr_flag = 2'b11;
    tick();
    clr_flag = 2'b00;
    tick();

    // ---- 3: clear collides with flag set ----
    set_ch(0, 1023, 3);
    enable_irq = 2'b01;
    load[0] = 1'b1;
    wait_ovf(0, 50, 1'b0, n);
    check("ch0_short_first", n, 5);
    clr_flag[0] = 1'b1;
    tick();
    check("clr_prio_flag", flag[0], 0);
    check("clr_prio_irq_n", irq_n, 1);
    clr_flag[0] = 1'b0;
    load[0] = 1'b0;
    tick();
    check("clr_prio_flag_after", flag[0], 0);
    check("clr_prio_irq_n_after", irq_n, 1);

    // ---- 4: masked IRQ, simultaneous overflows ----
    enable_irq = 2'b10;
    set_ch(1, 1023, 3);
    load = 2'b11;
    wait_ovf(0, 50, 1'b0, n);
    check("both_first", n, 5);
    check("both_overflow", overflow, 2'b11);
    tick();
    check("both_flags", flag, 2'b11);
    check("irq_n_lag", irq_n, 1);
    tick();
    check("irq_n_ch1", irq_n, 0);
    load = 2'b00;
    clr_flag = 2'b10;
    tick();
    clr_flag = 2'b00;
    check("flag_after_clr1", flag, 2'b01);
    tick();
    check("irq_n_masked_ch0", irq_n, 1);
    check("flag0_kept", flag[0], 1);

    // ---- 5: async reset mid-count ----
    enable_irq = 2'b01;
    set_ch(0, 1023, 3);
    load[0] = 1'b1;
    tick(); tick();
    check("pre_rst_irq_n", irq_n, 0);
    #3 rst = 1'b1;
    #1;
    check("async_rst_flag", flag, 0);
    check("async_rst_overflow", overflow, 0);
    check("async_rst_irq_n", irq_n, 1);
    check("async_rst_csm", csm_keyon, 0);
    #2 rst = 1'b0;
    load = 2'b00; enable_irq = 2'b00;
    tick(); tick();

    // ---- 6: CSM key-on ----
    csm_mode = 1'b1;
    set_ch(0, 1023, 1);
    load[0] = 1'b1;
    wait_ovf(0, 20, 1'b0, n);
    check("csm_first", n, 3);
    check("csm_pulse", csm_keyon, CSM_EXP);
    tick();
    check("csm_pulse_end", csm_keyon, 0);
    csm_mode = 1'b0;
    wait_ovf(0, 20, 1'b0, n);
    check("csm_period", n, 1);
    check("csm_off", csm_keyon, 0);
    load[0] = 1'b0;
    tick();

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
